// File: rtl/ls_pio_pkg.sv
// Shared constants and helpers for the filtered low-speed input PIO.
package ls_pio_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_COUNT = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } edge_type_e;

    // Bits needed to hold values 0..value-1, never less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ls_pio_glitch_filter.sv
// Single-bit glitch filter: accepts a new level only after it has differed
// from the current output for FILTER_CYCLES consecutive cycles.
module ls_pio_glitch_filter
    import ls_pio_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_bit,
    output logic filt_bit
);

    localparam int CNT_W = clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             filt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg  <= '0;
            filt_reg <= 1'b0;
        end else if (sync_bit == filt_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            filt_reg <= sync_bit;
            cnt_reg  <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign filt_bit = filt_reg;

endmodule

// File: rtl/ls_input_pio_filtered.sv
// Avalon-MM input PIO with synchroniser, per-bit glitch filter, edge capture,
// masked level interrupt and a saturating event counter.
module ls_input_pio_filtered
    import ls_pio_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0,
    parameter int EDGE_TYPE     = 0,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam int ARM   = SYNC_STAGES + FILTER_CYCLES + 2;
    localparam int ARM_W = clog2(ARM + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_reg;
    logic [DATA_WIDTH-1:0]  sync_q;
    logic [DATA_WIDTH-1:0]  filt;
    logic [DATA_WIDTH-1:0]  filt_d1_reg;
    logic [DATA_WIDTH-1:0]  edge_raw;
    logic [DATA_WIDTH-1:0]  edge_detect;
    logic [DATA_WIDTH-1:0]  edge_capture_reg;
    logic [DATA_WIDTH-1:0]  edge_capture_next;
    logic [DATA_WIDTH-1:0]  irq_mask_reg;
    logic [DATA_WIDTH-1:0]  w1c;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic [ARM_W-1:0]       arm_cnt_reg;
    logic [31:0]            read_next;
    logic                   armed;
    logic                   wr;
    logic                   event_any;
    logic                   unused_bits;

    assign unused_bits = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync_q = sync_reg[SYNC_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            assign filt = sync_q;
        end else begin : g_filter
            for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
                ls_pio_glitch_filter #(
                    .FILTER_CYCLES(FILTER_CYCLES)
                ) u_filter (
                    .clk     (clk),
                    .reset   (reset),
                    .sync_bit(sync_q[gi]),
                    .filt_bit(filt[gi])
                );
            end
        end
    endgenerate

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
            assign edge_raw = ~filt & filt_d1_reg;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_raw = filt ^ filt_d1_reg;
        end else begin : g_rise
            assign edge_raw = filt & ~filt_d1_reg;
        end
    endgenerate

    // Edges are ignored until the whole input pipeline has refilled after
    // reset, so inputs that were already active do not look like new events.
    assign armed       = (arm_cnt_reg == ARM_LAST);
    assign edge_detect = armed ? edge_raw : '0;
    assign event_any   = |edge_detect;
    assign wr          = chipselect & ~write_n;

    // A new edge wins over a simultaneous clear so no event is lost.
    assign w1c               = (wr && address == ADDR_EDGE) ? writedata[DATA_WIDTH-1:0] : '0;
    assign edge_capture_next = (edge_capture_reg & ~w1c) | edge_detect;

    always_comb begin
        read_next = '0;
        case (address)
            ADDR_DATA:  read_next[DATA_WIDTH-1:0]  = filt;
            ADDR_COUNT: read_next[COUNT_WIDTH-1:0] = count_reg;
            ADDR_MASK:  read_next[DATA_WIDTH-1:0]  = irq_mask_reg;
            default:    read_next[DATA_WIDTH-1:0]  = edge_capture_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_d1_reg      <= '0;
            arm_cnt_reg      <= '0;
            edge_capture_reg <= '0;
            irq_mask_reg     <= '0;
            count_reg        <= '0;
            readdata         <= '0;
            irq              <= 1'b0;
        end else begin
            filt_d1_reg      <= filt;
            edge_capture_reg <= edge_capture_next;
            readdata         <= read_next;
            irq              <= |(edge_capture_reg & irq_mask_reg);
            if (!armed) begin
                arm_cnt_reg <= arm_cnt_reg + 1'b1;
            end
            if (wr && address == ADDR_MASK) begin
                irq_mask_reg <= writedata[DATA_WIDTH-1:0];
            end
            if (wr && address == ADDR_COUNT) begin
                count_reg <= COUNT_WIDTH'(event_any);
            end else if (event_any && count_reg != '1) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule
